debug_dmi_arb: RTL and testbench

DEBUG_DMI_ARB -- requirements
Module: debug_dmi_arb

---
 rtl/debug_dmi_arb.sv | 213 +++++++++++++++++++++
 tb/tb_debug_dmi_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dmi_arb.sv
// -----------------------------------------------------------------------------
// debug_dmi_arb
// Arbitrates two debug requesters (R0, R1) onto a single debug-module access
// port. Requests are granted round-robin, issued to the debug module as a
// one-cycle DM_EN strobe, and completed with a one-cycle ACK to the requester.
//
// Ports
//   TCK, TRSTN          clock, asynchronous active-low reset
//   Rn_REQ/WR/AD/DO     requester n command (held until Rn_ACK)
//   Rn_ACK/ERR/DI       requester n completion pulse, timeout flag, read data
//   DM_EN/WR/AD/DO      access strobe and qualifiers to the debug module
//   DM_DI, DM_RDY       debug module read data and completion
//   BUSY                arbiter not idle
//
// Optional feature
//   DEBUG_DMI_ARB_TIMEOUT_EN  when defined, an access that sees no DM_RDY for
//                             TMO_CYCLES wait cycles completes with ERR=1.
// -----------------------------------------------------------------------------
module debug_dmi_arb #(
   parameter int unsigned AW         = 8,
   parameter logic [15:0] TMO_CYCLES = 16'd1023
) (
   input  logic          TCK,
   input  logic          TRSTN,
   input  logic          R0_REQ,
   input  logic          R0_WR,
   input  logic [AW-1:0] R0_AD,
   input  logic [31:0]   R0_DO,
   output logic          R0_ACK,
   output logic          R0_ERR,
   output logic [31:0]   R0_DI,
   input  logic          R1_REQ,
   input  logic          R1_WR,
   input  logic [AW-1:0] R1_AD,
   input  logic [31:0]   R1_DO,
   output logic          R1_ACK,
   output logic          R1_ERR,
   output logic [31:0]   R1_DI,
   output logic          DM_EN,
   output logic          DM_WR,
   output logic [AW-1:0] DM_AD,
   output logic [31:0]   DM_DO,
   input  logic [31:0]   DM_DI,
   input  logic          DM_RDY,
   output logic          BUSY
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic          gnt_q, gnt_d;       // requester owning the current access
   logic          prio_q, prio_d;     // requester that wins a simultaneous request
   logic          sel;                // arbitration result for this cycle
   logic          dm_en_q, dm_en_d;
   logic          dm_wr_q, dm_wr_d;
   logic [AW-1:0] dm_ad_q, dm_ad_d;
   logic [DW-1:0] dm_do_q, dm_do_d;
   logic [1:0]    ack_q, ack_d;
   logic [DW-1:0] di0_q, di0_d;
   logic [DW-1:0] di1_q, di1_d;
   logic          busy_q, busy_d;
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
   logic [1:0]    err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_hit;
`endif

   // State register
   always_ff @(posedge TCK or negedge TRSTN) begin
      if (!TRSTN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, arbitration and registered-output logic
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      prio_d  = prio_q;
      dm_en_d = 1'b0;
      dm_wr_d = dm_wr_q;
      dm_ad_d = dm_ad_q;
      dm_do_d = dm_do_q;
      ack_d   = 2'b00;
      di0_d   = di0_q;
      di1_d   = di1_q;
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
      err_d   = 2'b00;
      cnt_d   = cnt_q;
      // Fires on the TMO_CYCLES-th wait edge without DM_RDY
      tmo_hit = ((CW + 1)'(cnt_q) + (CW + 1)'(1)) >= (CW + 1)'(TMO_CYCLES);
`endif
      // Sole requester wins; on a tie the priority pointer decides
      sel     = (R0_REQ && R1_REQ) ? prio_q : R1_REQ;

      case (state_q)
         IDLE: begin
            if (R0_REQ || R1_REQ) begin
               gnt_d   = sel;
               prio_d  = ~sel;
               dm_wr_d = sel ? R1_WR : R0_WR;
               dm_ad_d = sel ? R1_AD : R0_AD;
               dm_do_d = sel ? R1_DO : R0_DO;
               dm_en_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (DM_RDY) begin
               ack_d[gnt_q] = 1'b1;
               if (!dm_wr_q) begin
                  if (gnt_q) begin
                     di1_d = DM_DI;
                  end else begin
                     di0_d = DM_DI;
                  end
               end
               state_d = DONE;
            end
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               ack_d[gnt_q] = 1'b1;
               err_d[gnt_q] = 1'b1;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Output and datapath registers
   always_ff @(posedge TCK or negedge TRSTN) begin
      if (!TRSTN) begin
         gnt_q   <= 1'b0;
         prio_q  <= 1'b0;
         dm_en_q <= 1'b0;
         dm_wr_q <= 1'b0;
         dm_ad_q <= '0;
         dm_do_q <= '0;
         ack_q   <= 2'b00;
         di0_q   <= '0;
         di1_q   <= '0;
         busy_q  <= 1'b0;
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
         err_q   <= 2'b00;
         cnt_q   <= '0;
`endif
      end else begin
         gnt_q   <= gnt_d;
         prio_q  <= prio_d;
         dm_en_q <= dm_en_d;
         dm_wr_q <= dm_wr_d;
         dm_ad_q <= dm_ad_d;
         dm_do_q <= dm_do_d;
         ack_q   <= ack_d;
         di0_q   <= di0_d;
         di1_q   <= di1_d;
         busy_q  <= busy_d;
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign DM_EN  = dm_en_q;
   assign DM_WR  = dm_wr_q;
   assign DM_AD  = dm_ad_q;
   assign DM_DO  = dm_do_q;
   assign R0_ACK = ack_q[0];
   assign R1_ACK = ack_q[1];
   assign R0_DI  = di0_q;
   assign R1_DI  = di1_q;
   assign BUSY   = busy_q;

`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
   assign R0_ERR = err_q[0];
   assign R1_ERR = err_q[1];
`else
   // Without the timeout an access can only end on DM_RDY, so ERR never sets
   assign R0_ERR = 1'b0;
   assign R1_ERR = 1'b0;
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYCLES;
`endif

endmodule

// File: tb/tb_debug_dmi_arb.sv
module tb_debug_dmi_arb;

   localparam int unsigned AW  = 8;
   localparam int          TMO = 16;

   logic          TCK = 1'b0;
   logic          TRSTN;
   logic          R0_REQ, R0_WR, R1_REQ, R1_WR;
   logic [AW-1:0] R0_AD, R1_AD;
   logic [31:0]   R0_DO, R1_DO;
   logic          R0_ACK, R0_ERR, R1_ACK, R1_ERR;
   logic [31:0]   R0_DI, R1_DI;
   logic          DM_EN, DM_WR, DM_RDY, BUSY;
   logic [AW-1:0] DM_AD;
   logic [31:0]   DM_DO, DM_DI;

   debug_dmi_arb #(.AW(AW), .TMO_CYCLES(16'(TMO))) dut (
      .TCK(TCK), .TRSTN(TRSTN),
      .R0_REQ(R0_REQ), .R0_WR(R0_WR), .R0_AD(R0_AD), .R0_DO(R0_DO),
      .R0_ACK(R0_ACK), .R0_ERR(R0_ERR), .R0_DI(R0_DI),
      .R1_REQ(R1_REQ), .R1_WR(R1_WR), .R1_AD(R1_AD), .R1_DO(R1_DO),
      .R1_ACK(R1_ACK), .R1_ERR(R1_ERR), .R1_DI(R1_DI),
      .DM_EN(DM_EN), .DM_WR(DM_WR), .DM_AD(DM_AD), .DM_DO(DM_DO),
      .DM_DI(DM_DI), .DM_RDY(DM_RDY), .BUSY(BUSY)
   );

   always #5 TCK = ~TCK;

   int errors = 0;
   int checks = 0;
   int e      = 0;   // index of the most recent rising edge

   // Transaction-level reference: an access granted at edge g shows DM_EN
   // after edge g, may complete on any edge >= g+2 that samples DM_RDY, and the
   // arbiter accepts again two edges after the completing edge.
   bit            m_busy, m_rr, m_g, m_err;
   int            m_gedge, m_ackedge, m_free;
   logic          m_wr;
   logic [AW-1:0] m_ad;
   logic [31:0]   m_do, m_di0, m_di1;

   bit auto_req, auto_dm, act0, act1;
   int p_start, p_new, p_drop, p_rdy;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_rr = 0; m_g = 0; m_err = 0;
      m_gedge = -100; m_ackedge = -100; m_free = 0;
      m_wr = 1'b0; m_ad = '0; m_do = '0; m_di0 = '0; m_di1 = '0;
   endtask

   task automatic model_step();
      if (!TRSTN) begin
         model_reset();
         return;
      end
      if (!m_busy && e >= m_free && (R0_REQ || R1_REQ)) begin
         m_g     = (R0_REQ && R1_REQ) ? m_rr : R1_REQ;
         m_rr    = !m_g;
         m_gedge = e;
         m_busy  = 1;
         m_wr    = m_g ? R1_WR : R0_WR;
         m_ad    = m_g ? R1_AD : R0_AD;
         m_do    = m_g ? R1_DO : R0_DO;
      end else if (m_busy && e >= m_gedge + 2) begin
         if (DM_RDY) begin
            m_ackedge = e; m_err = 0; m_busy = 0; m_free = e + 2;
            if (!m_wr) begin
               if (m_g) m_di1 = DM_DI;
               else     m_di0 = DM_DI;
            end
         end
`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
         else if (e - m_gedge - 1 >= TMO) begin
            m_ackedge = e; m_err = 1; m_busy = 0; m_free = e + 2;
         end
`endif
      end
   endtask

   task automatic check_outputs();
      bit x_en, x_ack;
      x_en  = (e == m_gedge);
      x_ack = (e == m_ackedge);
      chk1("dm_en", DM_EN, x_en);
      chk1("busy", BUSY, m_busy || x_ack);
      chk1("r0_ack", R0_ACK, x_ack && !m_g);
      chk1("r1_ack", R1_ACK, x_ack && m_g);
      chk1("r0_err", R0_ERR, x_ack && !m_g && m_err);
      chk1("r1_err", R1_ERR, x_ack && m_g && m_err);
      chk1("dm_wr", DM_WR, m_wr);
      chk32("dm_ad", 32'(DM_AD), 32'(m_ad));
      chk32("dm_do", DM_DO, m_do);
      chk32("r0_di", R0_DI, m_di0);
      chk32("r1_di", R1_DI, m_di1);
   endtask

   task automatic agent(input bit ack, input bit granted, inout bit act, inout logic req,
                        inout logic wr, inout logic [AW-1:0] ad, inout logic [31:0] dout);
      if (ack) begin
         act = 0;
         if (pct(p_new)) begin
            act = 1; req = 1'b1; wr = 1'($urandom); ad = AW'($urandom); dout = $urandom;
         end else begin
            req = 1'b0;
         end
      end else if (!act) begin
         if (pct(p_start)) begin
            act = 1; req = 1'b1; wr = 1'($urandom); ad = AW'($urandom); dout = $urandom;
         end
      end else if (granted && req && pct(p_drop)) begin
         req = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge TCK);
      #1;
      e++;
      model_step();
      check_outputs();
      if (auto_req) begin
         agent(R0_ACK, e == m_gedge && !m_g, act0, R0_REQ, R0_WR, R0_AD, R0_DO);
         agent(R1_ACK, e == m_gedge && m_g, act1, R1_REQ, R1_WR, R1_AD, R1_DO);
      end
      if (auto_dm) begin
         DM_RDY = pct(p_rdy);
         DM_DI  = $urandom;
      end
   endtask

   task automatic wait_ack(input bit n, input int maxc, output int cyc);
      bit got;
      got = 0;
      cyc = 0;
      for (int i = 0; i < maxc && !got; i++) begin
         tick();
         cyc++;
         got = n ? R1_ACK : R0_ACK;
      end
      chk1("ack_seen", got, 1'b1);
      if (n) R1_REQ = 1'b0;
      else   R0_REQ = 1'b0;
   endtask

   int order[$];
   int cyc, cnt;

   initial begin
      TRSTN = 1'b1;
      R0_REQ = 0; R0_WR = 0; R0_AD = '0; R0_DO = '0;
      R1_REQ = 0; R1_WR = 0; R1_AD = '0; R1_DO = '0;
      DM_RDY = 0; DM_DI = '0;
      auto_req = 0; auto_dm = 0; act0 = 0; act1 = 0;
      p_start = 0; p_new = 0; p_drop = 0; p_rdy = 0;
      model_reset();

      // Asynchronous reset before any clock edge
      #2 TRSTN = 1'b0;
      #1;
      chk1("rst_busy", BUSY, 1'b0);
      chk1("rst_dm_en", DM_EN, 1'b0);
      chk1("rst_dm_wr", DM_WR, 1'b0);
      chk32("rst_dm_ad", 32'(DM_AD), 32'h0);
      chk32("rst_dm_do", DM_DO, 32'h0);
      chk32("rst_r0_di", R0_DI, 32'h0);
      chk1("rst_r0_ack", R0_ACK, 1'b0);
      repeat (3) tick();
      TRSTN = 1'b1;

      // Single read from R0
      R0_REQ = 1; R0_WR = 0; R0_AD = 8'h11;
      tick();
      chk1("rd_dm_en", DM_EN, 1'b1);
      chk32("rd_dm_ad", 32'(DM_AD), 32'h11);
      chk1("rd_dm_wr", DM_WR, 1'b0);
      DM_RDY = 1; DM_DI = 32'hDEADBEEF;
      wait_ack(0, 10, cyc);
      chk32("rd_latency", 32'(cyc), 32'd2);
      chk32("rd_data", R0_DI, 32'hDEADBEEF);
      chk1("rd_err", R0_ERR, 1'b0);
      DM_RDY = 0;
      tick();

      // Write from R1
      R1_REQ = 1; R1_WR = 1; R1_AD = 8'h10; R1_DO = 32'h1;
      tick();
      chk1("wr_dm_en", DM_EN, 1'b1);
      chk1("wr_dm_wr", DM_WR, 1'b1);
      chk32("wr_dm_do", DM_DO, 32'h1);
      DM_RDY = 1;
      wait_ack(1, 10, cyc);
      chk32("wr_latency", 32'(cyc), 32'd2);
      chk32("wr_r1_di", R1_DI, 32'h0);
      DM_RDY = 0;
      tick();

      // Contention: both requesters keep requesting
      auto_req = 1; p_start = 100; p_new = 100; p_drop = 0;
      DM_RDY = 1;
      repeat (24) begin
         tick();
         if (R0_ACK) order.push_back(0);
         if (R1_ACK) order.push_back(1);
      end
      p_start = 0; p_new = 0;
      for (int i = 0; i < 20 && (act0 || act1); i++) tick();
      auto_req = 0;
      chk1("cont_drain", act0 || act1, 1'b0);
      chk1("cont_count", order.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < order.size(); i++)
         chk32($sformatf("cont_order%0d", i), 32'(order[i]), 32'(i % 2));
      DM_RDY = 0;
      tick();

      // R0 drops REQ while the access is in flight
      R0_REQ = 1; R0_WR = 0; R0_AD = 8'h22;
      tick();
      tick();
      R0_REQ = 0;
      tick();
      tick();
      DM_RDY = 1; DM_DI = 32'h12345678;
      cnt = 0;
      repeat (4) begin
         tick();
         if (R0_ACK) cnt++;
      end
      chk32("drop_ack_cnt", 32'(cnt), 32'd1);
      DM_RDY = 0;

`ifdef DEBUG_DMI_ARB_TIMEOUT_EN
      // No DM_RDY: timeout after TMO wait cycles
      R0_REQ = 1; R0_WR = 0; R0_AD = 8'h33;
      tick();
      wait_ack(0, 40, cyc);
      chk32("tmo_latency", 32'(cyc), 32'(TMO + 1));
      chk1("tmo_err", R0_ERR, 1'b1);
      chk32("tmo_di", R0_DI, 32'h12345678);
      tick();
      // DM_RDY on the timeout edge wins
      R1_REQ = 1; R1_WR = 0; R1_AD = 8'h44;
      tick();
      repeat (TMO) tick();
      DM_RDY = 1; DM_DI = 32'hCAFEF00D;
      tick();
      chk1("tmo_race_ack", R1_ACK, 1'b1);
      chk1("tmo_race_err", R1_ERR, 1'b0);
      chk32("tmo_race_di", R1_DI, 32'hCAFEF00D);
      R1_REQ = 0; DM_RDY = 0;
      tick();
`else
      // No DM_RDY: the access waits indefinitely
      R0_REQ = 1; R0_WR = 0; R0_AD = 8'h33;
      tick();
      repeat (40) tick();
      chk1("wait_busy", BUSY, 1'b1);
      chk1("wait_no_ack", R0_ACK, 1'b0);
      DM_RDY = 1; DM_DI = 32'hA5A5A5A5;
      wait_ack(0, 4, cyc);
      chk32("wait_latency", 32'(cyc), 32'd1);
      chk1("wait_err", R0_ERR, 1'b0);
      DM_RDY = 0;
      tick();
`endif

      // Reset while waiting on the debug module
      R1_REQ = 1; R1_WR = 0; R1_AD = 8'h55;
      tick();
      tick();
      #2 TRSTN = 1'b0;
      #1;
      chk1("rstw_busy", BUSY, 1'b0);
      chk1("rstw_dm_en", DM_EN, 1'b0);
      chk32("rstw_dm_ad", 32'(DM_AD), 32'h0);
      chk32("rstw_r0_di", R0_DI, 32'h0);
      chk1("rstw_r1_ack", R1_ACK, 1'b0);
      R1_REQ = 0;
      tick();
      TRSTN = 1'b1;
      R0_REQ = 1; R0_WR = 0; R0_AD = 8'h66;
      R1_REQ = 1; R1_WR = 0; R1_AD = 8'h77;
      tick();
      chk32("rstw_first_gnt", 32'(DM_AD), 32'h66);
      DM_RDY = 1;
      wait_ack(0, 6, cyc);
      wait_ack(1, 10, cyc);
      DM_RDY = 0;
      tick();

      // Randomized traffic
      auto_req = 1; auto_dm = 1;
      p_start = 40; p_new = 30; p_drop = 10; p_rdy = 35;
      repeat (3000) tick();
      p_start = 0; p_new = 0;
      for (int i = 0; i < 400 && (act0 || act1); i++) tick();
      chk1("rand_drain", act0 || act1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
